sram_mem_arbiter: RTL
=====================

Name: sram_mem_arbiter

Overview:
- Shares one single-port SRAM macro between two native-memory-interface masters: m0 (CPU core port) and m1 (DMA/debug port).
- Accepts valid/ready requests, arbitrates between them, and issues one SRAM command at a time.
- Captures the SRAM's one-cycle-delayed read data and returns it with a one-cycle ready pulse.
- Sits between the core wrapper and the SRAM macro.

Parameters:
- SRAM_AW, 8, SRAM word-address width (256 x 32-bit words).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- m0_valid  in  1  master 0 request; held high until m0_ready.
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 = read.
- m0_ready  out  1  master 0 one-cycle completion pulse.
- m0_rdata  out  32  master 0 read data, valid while m0_ready=1.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same widths and meaning for master 1.
- sram_csb0  out  1  SRAM chip select, active-low.
- sram_web0  out  1  SRAM write enable, active-low.
- sram_wmask0  out  4  SRAM byte write mask.
- sram_addr0  out  SRAM_AW  SRAM word address.
- sram_din0  out  32  SRAM write data.
- sram_dout0  in  32  SRAM read data, valid the cycle after the command cycle.
- arb_gnt  out  2  one-hot owner of the current transaction; 00 when idle.

Behaviour:
- All outputs are registered.
- Reset values:
  - sram_csb0=1, sram_web0=1.
  - sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - m0_ready=m1_ready=0, m0_rdata=m1_rdata=0.
  - arb_gnt=00, state=IDLE, last_grant=m1.
- FSM states: IDLE -> CMD -> DATA -> DONE -> IDLE.
- IDLE: arbitration on the sampled valids.
  - Only one valid: grant it.
  - Both valid: grant the master that is not last_grant.
  - At the grant edge, latch addr[SRAM_AW+1:2], wdata, wstrb into the SRAM command registers.
  - Same edge: set arb_gnt, update last_grant, go to CMD.
- CMD (1 cycle): drive the SRAM command.
  - sram_csb0=0.
  - sram_web0=0 iff latched wstrb!=0.
  - sram_wmask0=wstrb.
- DATA (1 cycle):
  - csb0=1, web0=1, wmask0=0.
  - On a read, the granted master's rdata <= sram_dout0 at the end of the cycle.
  - On a write, the granted master's rdata holds its previous value.
- DONE (1 cycle): granted master's ready=1. All valids are ignored here, because masters drop valid on the same edge that samples ready. Go to IDLE; arb_gnt -> 00.
- Latency and throughput:
  - ready is high in the 3rd cycle after the IDLE edge that sampled valid.
  - Peak throughput is one access per 4 cycles; reads and writes have identical latency.
- Address bits [1:0] and bits above SRAM_AW+1 are ignored; addresses alias.
- The ungranted master's ready stays 0 and its rdata is untouched. Its request waits and is served in the next IDLE.
- If valid drops before ready (protocol violation), the transaction still completes and ready still pulses.
- Reset asserted mid-transaction: outputs return asynchronously to reset values and the in-flight access is abandoned. csb0 deasserts immediately.

Optional Feature:
- SRAM_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins when both masters are valid; last_grant is unused. m1 can starve.
- Undefined: round-robin as described above, so each master waits at most one transaction.

Test Plan:
- Single write: m0 writes addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> CMD cycle shows csb0=0, web0=0, addr0=0x04, din0=0xDEADBEEF, wmask0=0xF; m0_ready pulses 3 cycles after the grant edge.
- Read-back: m0 reads 0x10 with SRAM model returning 0xDEADBEEF -> m0_rdata=0xDEADBEEF while m0_ready=1; web0 stays 1.
- Partial write: m1 writes wstrb=0x3 to 0x20 -> wmask0=0x3, addr0=0x08. A later read of 0x20 returns new low half and old upper half.
- Contention: m0 and m1 both valid from reset -> m0 served first, then m1; arb_gnt=01 then 10. Repeat with both valid -> order alternates (macro undefined). With SRAM_ARB_FIXED_PRIO_EN, m0 is served every time.
- Held valid: m0 keeps valid high through DONE and drops it on the ready edge -> exactly one SRAM access and one ready pulse; no duplicate grant.
- Reset mid-operation: resetn=0 during CMD -> csb0=1 and ready=0 immediately. After release, a new m1 read completes normally with 3-cycle latency.

Source files
------------

// File: rtl/sram_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sram_mem_arbiter
//
// Shares one single-port SRAM macro between two native-memory-interface
// masters: m0 (CPU core port) and m1 (DMA/debug port). A request is accepted
// in IDLE, and one SRAM command is issued in CMD. The macro's one-cycle-late
// read data is captured in DATA. The granted master then sees a one-cycle
// ready pulse in DONE.
//
// Optional build macro:
//   SRAM_ARB_FIXED_PRIO_EN  defined   -> m0 always wins a tie (m1 can starve)
//                           undefined -> round-robin on ties (default)
//
// Ports:
//   clk, resetn                 clock (rising edge), async active-low reset
//   mN_valid/addr/wdata/wstrb   master N request (wstrb==0 means read)
//   mN_ready                    master N one-cycle completion pulse
//   mN_rdata                    master N read data, valid while mN_ready=1
//   sram_csb0/web0              SRAM chip select / write enable (active-low)
//   sram_wmask0                 SRAM byte write mask
//   sram_addr0                  SRAM word address
//   sram_din0                   SRAM write data
//   sram_dout0                  SRAM read data (cycle after the command)
//   arb_gnt                     one-hot owner of current transaction, 00 idle
// ---------------------------------------------------------------------------
module sram_mem_arbiter #(
  parameter int SRAM_AW = 8
) (
  input  logic               clk,
  input  logic               resetn,

  input  logic               m0_valid,
  input  logic [31:0]        m0_addr,
  input  logic [31:0]        m0_wdata,
  input  logic [3:0]         m0_wstrb,
  output logic               m0_ready,
  output logic [31:0]        m0_rdata,

  input  logic               m1_valid,
  input  logic [31:0]        m1_addr,
  input  logic [31:0]        m1_wdata,
  input  logic [3:0]         m1_wstrb,
  output logic               m1_ready,
  output logic [31:0]        m1_rdata,

  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [3:0]         sram_wmask0,
  output logic [SRAM_AW-1:0] sram_addr0,
  output logic [31:0]        sram_din0,
  input  logic [31:0]        sram_dout0,

  output logic [1:0]         arb_gnt
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t               state_q;
  logic                 csb_q;
  logic                 web_q;
  logic [3:0]           wmask_q;
  logic [SRAM_AW-1:0]   addr_q;
  logic [31:0]          din_q;
  logic                 m0_ready_q;
  logic                 m1_ready_q;
  logic [31:0]          m0_rdata_q;
  logic [31:0]          m1_rdata_q;
  logic [1:0]           gnt_q;
  logic                 is_read_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  // 1 = m1 owned the most recent transaction.
  logic                 last_grant_q;
`endif

  // Arbitration decision and selected command, evaluated in IDLE only.
  logic                 grant_m1_d;
  logic [SRAM_AW-1:0]   cmd_addr_d;
  logic [31:0]          cmd_wdata_d;
  logic [3:0]           cmd_wstrb_d;

  always_comb begin
    grant_m1_d = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    grant_m1_d = m1_valid && !m0_valid;
`else
    // On a tie, the master that did not own the last transaction wins.
    grant_m1_d = m1_valid && (!m0_valid || !last_grant_q);
`endif
    cmd_addr_d  = grant_m1_d ? m1_addr[SRAM_AW+1:2] : m0_addr[SRAM_AW+1:2];
    cmd_wdata_d = grant_m1_d ? m1_wdata : m0_wdata;
    cmd_wstrb_d = grant_m1_d ? m1_wstrb : m0_wstrb;
  end

  // Byte-offset bits and bits above the SRAM window are ignored; addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:SRAM_AW+2], m0_addr[1:0],
                              m1_addr[31:SRAM_AW+2], m1_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= 4'h0;
      addr_q       <= '0;
      din_q        <= 32'h0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_rdata_q   <= 32'h0;
      m1_rdata_q   <= 32'h0;
      gnt_q        <= 2'b00;
      is_read_q    <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            // The command is registered here so it is on the pins during CMD.
            csb_q        <= 1'b0;
            web_q        <= (cmd_wstrb_d == 4'h0);
            wmask_q      <= cmd_wstrb_d;
            addr_q       <= cmd_addr_d;
            din_q        <= cmd_wdata_d;
            is_read_q    <= (cmd_wstrb_d == 4'h0);
            gnt_q        <= grant_m1_d ? 2'b10 : 2'b01;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= grant_m1_d;
`endif
            state_q      <= CMD;
          end
        end
        CMD: begin
          csb_q   <= 1'b1;
          web_q   <= 1'b1;
          wmask_q <= 4'h0;
          state_q <= DATA;
        end
        DATA: begin
          // sram_dout0 is valid in this cycle; writes leave rdata untouched.
          if (is_read_q) begin
            if (gnt_q[1]) m1_rdata_q <= sram_dout0;
            else          m0_rdata_q <= sram_dout0;
          end
          m0_ready_q <= gnt_q[0];
          m1_ready_q <= gnt_q[1];
          state_q    <= DONE;
        end
        DONE: begin
          // Valids are ignored here: masters drop valid on this same edge.
          m0_ready_q <= 1'b0;
          m1_ready_q <= 1'b0;
          gnt_q      <= 2'b00;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign arb_gnt     = gnt_q;

endmodule
